// File: rtl/block_summarizer.sv
// block_summarizer: groups validator transactions into blocks and queues per-block
// summaries (index, count, amount sum, rolling hash) behind a valid/ready FIFO.
module block_summarizer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16,
  parameter int SUM_W      = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [127:0]       data_i,
  input  logic               valid_i,
  input  logic               flush_i,
  output logic               sum_valid_o,
  input  logic               sum_ready_i,
  output logic [15:0]        sum_index_o,
  output logic [COUNT_W-1:0] sum_count_o,
  output logic [SUM_W-1:0]   sum_amount_o,
  output logic [31:0]        sum_hash_o,
  output logic               ovf_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int W  = 48 + COUNT_W + SUM_W;
  typedef enum logic {IDLE, OPEN} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d, ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, b_cnt;
  logic [SUM_W-1:0] sum_q, sum_d, b_sum;
  logic [31:0] hash_q, hash_d, b_hash, fold;
  logic [15:0] idx_q, idx_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] push_data, head;
  logic open_new, close_old, close_new, push, pop, full, wr_en;
  assign sum_valid_o = fill_q != '0;
  assign head = sum_valid_o ? mem_q[rd_q] : '0;
  assign {sum_index_o, sum_count_o, sum_amount_o, sum_hash_o} = head;
  assign ovf_o = ovf_q;
  always_comb begin
    fold = data_i[127:96] ^ data_i[95:64] ^ data_i[63:32] ^ data_i[31:0];
    // A pending flush makes the next txn join the new block regardless of its start bit.
    open_new = valid_i && (state_q == IDLE || (data_i[9] && !pend_q));
    close_old = valid_i && state_q == OPEN && data_i[9] && !pend_q;
    b_cnt = open_new ? '0 : cnt_q;
    b_sum = open_new ? '0 : sum_q;
    b_hash = open_new ? '0 : hash_q;
    cnt_d = valid_i ? (&b_cnt ? b_cnt : b_cnt + 1'b1) : b_cnt;
    sum_d = valid_i ? b_sum + SUM_W'(data_i[31:10]) : b_sum;
    hash_d = valid_i ? {b_hash[26:0], b_hash[31:27]} ^ fold : b_hash;
    close_new = (flush_i || pend_q) && !close_old && (state_q == OPEN || valid_i);
    push = close_old || close_new;
    push_data = close_old ? {idx_q, cnt_q, sum_q, hash_q} : {idx_q, cnt_d, sum_d, hash_d};
    pend_d = close_old && flush_i;
    state_d = close_new ? IDLE : (valid_i ? OPEN : state_q);
    idx_d = idx_q + 16'(push);
    full = fill_q == FW'(FIFO_DEPTH);
    pop = sum_valid_o && sum_ready_i;
    wr_en = push && (!full || pop);
    wr_d = wr_q + AW'(wr_en);
    rd_d = rd_q + AW'(pop);
    fill_d = fill_q + FW'(wr_en) - FW'(pop);
    ovf_d = ovf_q || (push && !wr_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      hash_q <= '0;
      idx_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      hash_q <= hash_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fill_q <= fill_d;
    end
  end
  always_ff @(posedge clk) if (wr_en) mem_q[wr_q] <= push_data;
endmodule

// File: tb/tb_block_summarizer.sv
// tb_block_summarizer: directed tests of block grouping, summary queue and overflow.
module tb_block_summarizer;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, flush_i = 1'b0, sum_ready_i = 1'b0;
  logic [127:0] data_i = '0;
  logic sum_valid_o, ovf_o;
  logic [15:0] sum_index_o, sum_count_o;
  logic [39:0] sum_amount_o;
  logic [31:0] sum_hash_o;
  int n_tests = 0, n_fail = 0;

  block_summarizer dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .flush_i(flush_i),
    .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i), .sum_index_o(sum_index_o),
    .sum_count_o(sum_count_o), .sum_amount_o(sum_amount_o), .sum_hash_o(sum_hash_o),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] tx(input logic [21:0] a, input logic b);
    return {96'h0, a, b, 9'h0};
  endfunction

  task automatic cyc(input logic v, input logic f, input logic [127:0] d);
    valid_i = v;
    flush_i = f;
    data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sum_ready_i = 1'b0;
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o, sum_hash_o, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b idx=%h cnt=%h sum=%h hash=%h ovf=%b want all 0",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o, sum_hash_o, ovf_o);
    end
  endtask

  task automatic test_basic_block;
    do_reset();
    cyc(1, 0, tx(5, 1));
    cyc(1, 0, tx(7, 0));
    n_tests++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_no_early_summary got %b want 0", sum_valid_o);
    end
    cyc(0, 1, '0);
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd0, 16'd2, 40'd12}) begin
      n_fail++;
      $display("FAIL t1_summary got v=%b idx=%0d cnt=%0d sum=%0d want v=1 idx=0 cnt=2 sum=12",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
    n_tests++;
    if (sum_hash_o !== 32'h0002DC00) begin
      n_fail++;
      $display("FAIL t1_hash got %h want 0002dc00", sum_hash_o);
    end
    sum_ready_i = 1'b1;
    cyc(0, 0, '0);
    n_tests++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_pop got valid %b want 0", sum_valid_o);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    sum_ready_i = 1'b1;
    cyc(1, 0, {48'hABCD_0000_0000, 48'h0, 22'd3, 1'b1, 9'h0});
    cyc(1, 0, tx(100, 1));
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o, sum_hash_o} !==
        {1'b1, 16'd0, 16'd1, 40'd3, 32'hABCD0E00}) begin
      n_fail++;
      $display("FAIL t2_blk0 got v=%b idx=%0d cnt=%0d sum=%0d hash=%h want 1/0/1/3/abcd0e00",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o, sum_hash_o);
    end
    cyc(1, 0, tx(22'h3FFFFF, 1));
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd1, 16'd1, 40'd100}) begin
      n_fail++;
      $display("FAIL t2_blk1 got v=%b idx=%0d cnt=%0d sum=%0d want 1/1/1/100",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
    cyc(0, 1, '0);
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd2, 16'd1, 40'h3FFFFF}) begin
      n_fail++;
      $display("FAIL t2_blk2 got v=%b idx=%0d cnt=%0d sum=%h want 1/2/1/3fffff",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
    cyc(0, 0, '0);
    n_tests++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_drained got valid %b want 0", sum_valid_o);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, tx(22'(i + 1), 1));
    n_tests++;
    if ({ovf_o, sum_valid_o, sum_index_o, sum_amount_o} !== {1'b1, 1'b1, 16'd0, 40'd1}) begin
      n_fail++;
      $display("FAIL t3_full got ovf=%b v=%b idx=%0d sum=%0d want 1/1/0/1",
               ovf_o, sum_valid_o, sum_index_o, sum_amount_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({sum_valid_o, sum_index_o, sum_amount_o} !== {1'b1, 16'(i), 40'(i + 1)}) begin
        n_fail++;
        $display("FAIL t3_drain%0d got v=%b idx=%0d sum=%0d want v=1 idx=%0d sum=%0d",
                 i, sum_valid_o, sum_index_o, sum_amount_o, i, i + 1);
      end
      sum_ready_i = 1'b1;
      cyc(0, 0, '0);
    end
    n_tests++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_empty got valid %b want 0", sum_valid_o);
    end
    sum_ready_i = 1'b0;
    cyc(0, 1, '0);
    n_tests++;
    if ({ovf_o, sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !==
        {1'b1, 1'b1, 16'd5, 16'd1, 40'd6}) begin
      n_fail++;
      $display("FAIL t3_after_drop got ovf=%b v=%b idx=%0d cnt=%0d sum=%0d want 1/1/5/1/6",
               ovf_o, sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
  endtask

  task automatic test_mid_reset;
    sum_ready_i = 1'b0;
    cyc(1, 0, tx(1, 1));
    cyc(1, 0, tx(2, 1));
    cyc(1, 0, tx(3, 1));
    n_tests++;
    if ({ovf_o, sum_valid_o, sum_index_o} !== {1'b1, 1'b1, 16'd5}) begin
      n_fail++;
      $display("FAIL t6_pre got ovf=%b v=%b idx=%0d want 1/1/5", ovf_o, sum_valid_o, sum_index_o);
    end
    rst = 1'b1;
    cyc(0, 0, '0);
    rst = 1'b0;
    n_tests++;
    if ({ovf_o, sum_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL t6_cleared got ovf=%b v=%b want 0/0", ovf_o, sum_valid_o);
    end
    cyc(1, 0, tx(5, 0));
    cyc(0, 1, '0);
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd0, 16'd1, 40'd5}) begin
      n_fail++;
      $display("FAIL t6_fresh got v=%b idx=%0d cnt=%0d sum=%0d want 1/0/1/5",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
  endtask

  task automatic test_flush_with_start;
    do_reset();
    cyc(1, 0, tx(1, 1));
    cyc(1, 0, tx(2, 0));
    cyc(1, 0, tx(3, 0));
    cyc(1, 1, tx(10, 1));
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd0, 16'd3, 40'd6}) begin
      n_fail++;
      $display("FAIL t4_old got v=%b idx=%0d cnt=%0d sum=%0d want 1/0/3/6",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
    cyc(0, 0, '0);
    n_tests++;
    if ({sum_index_o, sum_count_o} !== {16'd0, 16'd3}) begin
      n_fail++;
      $display("FAIL t4_hold got idx=%0d cnt=%0d want 0/3", sum_index_o, sum_count_o);
    end
    sum_ready_i = 1'b1;
    cyc(0, 0, '0);
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd1, 16'd1, 40'd10}) begin
      n_fail++;
      $display("FAIL t4_new got v=%b idx=%0d cnt=%0d sum=%0d want 1/1/1/10",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
    cyc(0, 0, '0);
    n_tests++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_no_extra got valid %b want 0", sum_valid_o);
    end
    sum_ready_i = 1'b0;
    cyc(1, 0, tx(4, 0));
    cyc(0, 1, '0);
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd2, 16'd1, 40'd4}) begin
      n_fail++;
      $display("FAIL t4_idle got v=%b idx=%0d cnt=%0d sum=%0d want 1/2/1/4",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
  endtask

  task automatic test_idle_flush;
    do_reset();
    sum_ready_i = 1'b1;
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    n_tests++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_idle_flush got valid %b want 0", sum_valid_o);
    end
    cyc(0, 0, '0);
    n_tests++;
    if ({sum_valid_o, ovf_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL t5_empty_pop got v=%b ovf=%b want 0/0", sum_valid_o, ovf_o);
    end
    cyc(1, 0, tx(9, 0));
    sum_ready_i = 1'b0;
    cyc(0, 1, '0);
    n_tests++;
    if ({sum_valid_o, sum_index_o, sum_count_o, sum_amount_o} !== {1'b1, 16'd0, 16'd1, 40'd9}) begin
      n_fail++;
      $display("FAIL t5_first got v=%b idx=%0d cnt=%0d sum=%0d want 1/0/1/9",
               sum_valid_o, sum_index_o, sum_count_o, sum_amount_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_flush_with_start();
    test_idle_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
